// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-address width, writeback-select encodings
// and the execute-stage control bundle used by the ID/EX, EX/MEM and MEM/WB registers.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

    // ALU control is kept outside the struct because its width is a parameter of each stage.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       jalr_ctrl;
        logic       alu_src;
        logic [2:0] funct3;
    } ctrl_e_t;

    localparam int CTRL_E_W = $bits(ctrl_e_t);

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline flop bank: synchronous rst, then clear, then enable, in priority order.
// Latency 1 cycle; en_i=0 holds the stored value.
module pipe_reg_en_clr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register, 1-cycle latency; StallE holds, FlushE loads a bubble (flush wins).
// ID_EX_PERF_CNT_EN builds a saturating bubble/stall counter; otherwise BubbleCountE is tied to 0.
module decode_execute_reg
    import pipe_pkg::*;
#(
    parameter int D_WIDTH       = 32,
    parameter int ALUCTRL_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     StallE,
    input  logic                     FlushE,
    input  logic                     ValidD,
    input  logic                     RegWriteD,
    input  logic [1:0]               ResultSrcD,
    input  logic                     MemWriteD,
    input  logic                     JumpD,
    input  logic                     BranchD,
    input  logic                     JALRctrlD,
    input  logic                     ALUSrcD,
    input  logic [ALUCTRL_WIDTH-1:0] ALUControlD,
    input  logic [2:0]               funct3D,
    input  logic [D_WIDTH-1:0]       RD1D,
    input  logic [D_WIDTH-1:0]       RD2D,
    input  logic [D_WIDTH-1:0]       PCD,
    input  logic [D_WIDTH-1:0]       PCPlus4D,
    input  logic [D_WIDTH-1:0]       ImmExtD,
    input  logic [REG_ADDR_W-1:0]    Rs1D,
    input  logic [REG_ADDR_W-1:0]    Rs2D,
    input  logic [REG_ADDR_W-1:0]    RdD,
    output logic                     ValidE,
    output logic                     RegWriteE,
    output logic [1:0]               ResultSrcE,
    output logic                     MemWriteE,
    output logic                     JumpE,
    output logic                     BranchE,
    output logic                     JALRctrlE,
    output logic                     ALUSrcE,
    output logic [ALUCTRL_WIDTH-1:0] ALUControlE,
    output logic [2:0]               funct3E,
    output logic [D_WIDTH-1:0]       RD1E,
    output logic [D_WIDTH-1:0]       RD2E,
    output logic [D_WIDTH-1:0]       PCE,
    output logic [D_WIDTH-1:0]       PCPlus4E,
    output logic [D_WIDTH-1:0]       ImmExtE,
    output logic [REG_ADDR_W-1:0]    Rs1E,
    output logic [REG_ADDR_W-1:0]    Rs2E,
    output logic [REG_ADDR_W-1:0]    RdE,
    output logic [31:0]              BubbleCountE
);

    localparam int CTRL_W = CTRL_E_W + ALUCTRL_WIDTH;
    localparam int DATA_W = 5 * D_WIDTH + 3 * REG_ADDR_W;

    ctrl_e_t             ctrl_d;
    ctrl_e_t             ctrl_q;
    logic [CTRL_W-1:0]   ctrl_bus_q;
    logic [DATA_W-1:0]   data_bus_d;
    logic [DATA_W-1:0]   data_bus_q;
    logic                slot_live;

    // An invalid slot, or a write targeting x0, must never commit architectural state.
    assign slot_live = ValidD;

    always_comb begin
        ctrl_d            = '0;
        ctrl_d.valid      = ValidD;
        ctrl_d.reg_write  = RegWriteD & slot_live & (RdD != '0);
        ctrl_d.result_src = ResultSrcD;
        ctrl_d.mem_write  = MemWriteD & slot_live;
        ctrl_d.jump       = JumpD & slot_live;
        ctrl_d.branch     = BranchD & slot_live;
        ctrl_d.jalr_ctrl  = JALRctrlD;
        ctrl_d.alu_src    = ALUSrcD;
        ctrl_d.funct3     = funct3D;
    end

    assign data_bus_d = {RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};

    pipe_reg_en_clr #(.W(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .rst   (rst),
        .clr_i (FlushE),
        .en_i  (~StallE),
        .d_i   ({ctrl_d, ALUControlD}),
        .q_o   (ctrl_bus_q)
    );

    pipe_reg_en_clr #(.W(DATA_W)) u_data_reg (
        .clk   (clk),
        .rst   (rst),
        .clr_i (FlushE),
        .en_i  (~StallE),
        .d_i   (data_bus_d),
        .q_o   (data_bus_q)
    );

    assign ctrl_q      = ctrl_bus_q[CTRL_W-1:ALUCTRL_WIDTH];
    assign ALUControlE = ctrl_bus_q[ALUCTRL_WIDTH-1:0];
    assign ValidE      = ctrl_q.valid;
    assign RegWriteE   = ctrl_q.reg_write;
    assign ResultSrcE  = ctrl_q.result_src;
    assign MemWriteE   = ctrl_q.mem_write;
    assign JumpE       = ctrl_q.jump;
    assign BranchE     = ctrl_q.branch;
    assign JALRctrlE   = ctrl_q.jalr_ctrl;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign funct3E     = ctrl_q.funct3;

    assign {RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE} = data_bus_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((FlushE || StallE) && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign BubbleCountE = bubble_cnt_q;
`else
    assign BubbleCountE = '0;
`endif

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed bench for the ID/EX register: reset, load, x0 suppression, stall, flush, invalid slot, counter.
module tb_decode_execute_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, JALRctrlD, ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [3:0]  ALUControlD;
    logic [2:0]  funct3D;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;

    logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, JALRctrlE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  funct3E;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, BubbleCountE;
    logic [4:0]  Rs1E, Rs2E, RdE;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = '0;

    always #5 clk = ~clk;

    decode_execute_reg #(.D_WIDTH(32), .ALUCTRL_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .JALRctrlD(JALRctrlD), .ALUSrcD(ALUSrcD),
        .ALUControlD(ALUControlD), .funct3D(funct3D), .RD1D(RD1D), .RD2D(RD2D),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .JALRctrlE(JALRctrlE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .funct3E(funct3E), .RD1E(RD1E), .RD2E(RD2E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .BubbleCountE(BubbleCountE)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
        end
    endtask

    // One clock edge; the counter model follows the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
`ifdef ID_EX_PERF_CNT_EN
        if (rst) exp_cnt = '0;
        else if ((FlushE || StallE) && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
`endif
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        StallE = 0; FlushE = 0; ValidD = 0; RegWriteD = 0; MemWriteD = 0; JumpD = 0;
        BranchD = 0; JALRctrlD = 0; ALUSrcD = 0; ResultSrcD = '0; ALUControlD = '0;
        funct3D = '0; RD1D = '0; RD2D = '0; PCD = '0; PCPlus4D = '0; ImmExtD = '0;
        Rs1D = '0; Rs2D = '0; RdD = '0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        // Busy D inputs during reset: outputs must still read as a bubble.
        ValidD = 1; RegWriteD = 1; RdD = 5'd5; RD1D = 32'h0000_00AA; ALUControlD = 4'b0010;
        MemWriteD = 1; PCD = 32'h0000_0040;
        tick();
        tick();
        chk("rst_regwrite", {31'd0, RegWriteE}, 32'd0);
        chk("rst_valid",    {31'd0, ValidE},    32'd0);
        chk("rst_memwrite", {31'd0, MemWriteE}, 32'd0);
        chk("rst_rd",       {27'd0, RdE},       32'd0);
        chk("rst_rd1",      RD1E,               32'd0);
        chk("rst_pc",       PCE,                32'd0);
        chk("rst_aluctl",   {28'd0, ALUControlE}, 32'd0);
        chk("rst_cnt",      BubbleCountE,       32'd0);

        // 1: first load after reset
        rst = 1'b0; MemWriteD = 0;
        tick();
        chk("ld_regwrite", {31'd0, RegWriteE}, 32'd1);
        chk("ld_rd",       {27'd0, RdE},       32'd5);
        chk("ld_rd1",      RD1E,               32'h0000_00AA);
        chk("ld_aluctl",   {28'd0, ALUControlE}, 32'h2);

        // Full-field load
        clear_inputs();
        ValidD = 1; JumpD = 1; JALRctrlD = 1; ALUSrcD = 1; ResultSrcD = 2'b10; funct3D = 3'b101;
        RD2D = 32'hDEAD_BEEF; PCPlus4D = 32'h0000_1004; ImmExtD = 32'hFFFF_FFF0;
        Rs1D = 5'd17; Rs2D = 5'd31; RdD = 5'd1; RegWriteD = 1;
        tick();
        chk("full_jump",   {31'd0, JumpE},     32'd1);
        chk("full_jalr",   {31'd0, JALRctrlE}, 32'd1);
        chk("full_alusrc", {31'd0, ALUSrcE},   32'd1);
        chk("full_ressrc", {30'd0, ResultSrcE}, 32'd2);
        chk("full_funct3", {29'd0, funct3E},   32'd5);
        chk("full_rd2",    RD2E,               32'hDEAD_BEEF);
        chk("full_pc4",    PCPlus4E,           32'h0000_1004);
        chk("full_imm",    ImmExtE,            32'hFFFF_FFF0);
        chk("full_rs1",    {27'd0, Rs1E},      32'd17);
        chk("full_rs2",    {27'd0, Rs2E},      32'd31);
        chk("full_regwr",  {31'd0, RegWriteE}, 32'd1);

        // 2: x0 write suppression
        clear_inputs();
        ValidD = 1; RegWriteD = 1; RdD = 5'd0;
        tick();
        chk("x0_regwrite", {31'd0, RegWriteE}, 32'd0);
        chk("x0_rd",       {27'd0, RdE},       32'd0);
        chk("x0_valid",    {31'd0, ValidE},    32'd1);

        // 3: stall hold
        clear_inputs();
        ValidD = 1; PCD = 32'h0000_0100; RdD = 5'd9;
        tick();
        chk("stall_pre_pc", PCE, 32'h0000_0100);
        StallE = 1; PCD = 32'h0000_0200; RdD = 5'd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_pc_%0d", i), PCE, 32'h0000_0100);
        end
        chk("stall_rd", {27'd0, RdE}, 32'd9);
        StallE = 0;
        tick();
        chk("stall_rel_pc", PCE, 32'h0000_0200);
        chk("stall_rel_rd", {27'd0, RdE}, 32'd12);
        chk("cnt_after_stall", BubbleCountE, exp_cnt);

        // 4: flush and stall together
        clear_inputs();
        ValidD = 1; MemWriteD = 1; RdD = 5'd3; PCD = 32'h0000_0300;
        tick();
        chk("fl_pre_memwr", {31'd0, MemWriteE}, 32'd1);
        FlushE = 1; StallE = 1;
        tick();
        chk("fl_memwr", {31'd0, MemWriteE}, 32'd0);
        chk("fl_valid", {31'd0, ValidE},    32'd0);
        chk("fl_rd",    {27'd0, RdE},       32'd0);
        chk("fl_pc",    PCE,                32'd0);
        chk("fl_cnt",   BubbleCountE,       exp_cnt);

        // 5: invalid slot
        clear_inputs();
        ValidD = 0; MemWriteD = 1; BranchD = 1; JumpD = 1; RegWriteD = 1; RdD = 5'd7;
        tick();
        chk("inv_memwr",  {31'd0, MemWriteE}, 32'd0);
        chk("inv_branch", {31'd0, BranchE},   32'd0);
        chk("inv_jump",   {31'd0, JumpE},     32'd0);
        chk("inv_regwr",  {31'd0, RegWriteE}, 32'd0);
        chk("inv_rd",     {27'd0, RdE},       32'd7);

        // Reset during a stall discards held contents
        StallE = 1;
        rst = 1;
        tick();
        chk("rst_stall_rd",  {27'd0, RdE}, 32'd0);
        chk("rst_stall_cnt", BubbleCountE, exp_cnt);
        rst = 0; StallE = 0;
        tick();

        // 6: counter saturation
`ifdef ID_EX_PERF_CNT_EN
        force dut.bubble_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt_q;
        exp_cnt = 32'hFFFF_FFFE;
`endif
        StallE = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sat_cnt_%0d", i), BubbleCountE, exp_cnt);
        end
        StallE = 0; rst = 1;
        tick();
        chk("sat_rst_cnt", BubbleCountE, 32'd0);
        rst = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_execute_reg.md
Name: decode_execute_reg

Overview:
- ID/EX pipeline register sitting directly downstream of the decode control unit and register file.
- Captures decode-stage control signals, operands, immediates and register addresses each cycle, then presents them to the execute stage one cycle later.
- Supports a hazard-unit stall (hold) and flush (bubble insertion) for load-use hazards and taken branches/jumps.

Parameters:
- D_WIDTH, 32, datapath width of operands, PC and immediate.
- ALUCTRL_WIDTH, 4, width of the ALU control field from the ALU decoder.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous active-high reset.
- StallE  input  1  hold all E outputs this cycle.
- FlushE  input  1  load a bubble this cycle.
- ValidD  input  1  decode slot holds a real instruction.
- RegWriteD  input  1  register-file write enable.
- ResultSrcD  input  2  writeback select (00 ALU, 01 memory, 10 PC+4).
- MemWriteD  input  1  data-memory write enable.
- JumpD  input  1  JAL/JALR.
- BranchD  input  1  conditional branch.
- JALRctrlD  input  1  JALR target select.
- ALUSrcD  input  1  ALU B operand select (1 = immediate).
- ALUControlD  input  ALUCTRL_WIDTH  ALU operation.
- funct3D  input  3  branch condition / load-store size.
- RD1D, RD2D  input  D_WIDTH  register-file read data.
- PCD, PCPlus4D, ImmExtD  input  D_WIDTH  PC, PC+4, extended immediate.
- Rs1D, Rs2D, RdD  input  5  register addresses.
- Every D input has an E-suffixed output of the same width (ValidE … RdE).
- BubbleCountE  output  32  bubble/stall counter (see Optional Feature).

Behaviour:
- All state updates on the rising edge of clk. Priority per edge: rst > FlushE > StallE > normal load.
- Reset: every E output = 0, BubbleCountE = 0. This equals a NOP bubble.
- Normal load (no rst, FlushE=0, StallE=0): each E output takes its D input, so latency is exactly 1 cycle.
  - Exception: RegWriteE = RegWriteD & (RdD != 0). Writes to x0 are normalized away so forwarding and hazard logic never match x0.
- Flush (FlushE=1): all control outputs (ValidE, RegWriteE, MemWriteE, JumpE, BranchE, JALRctrlE, ALUSrcE, ResultSrcE, ALUControlE, funct3E) = 0. Rs1E, Rs2E and RdE = 0. Data outputs = 0.
- Stall (StallE=1, FlushE=0): every E output holds its previous value.
- FlushE and StallE both high: flush wins, and a bubble is loaded.
- ValidD=0 on a normal load: the slot is captured as-is, but RegWriteE, MemWriteE, JumpE and BranchE are forced to 0, so an invalid slot can never commit state.
- rst asserted mid-stall or mid-flush: reset takes effect on that edge, and the held contents are discarded.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: BubbleCountE increments by 1 on every non-reset edge where FlushE=1 or StallE=1. It saturates at 32'hFFFFFFFF with no wrap, and clears on rst.
- Undefined: the counter logic is not built, and BubbleCountE is tied to 0. The port list is identical either way.

Decomposition:
- Shared package pipe_pkg holds:
  - REG_ADDR_W = 5.
  - RESULT_SRC_ALU / RESULT_SRC_MEM / RESULT_SRC_PC4 encodings.
  - A packed struct ctrl_e_t bundling the E control bits, so decode/execute/memory registers share one definition.
- One natural sub-module: pipe_reg_en_clr, a parameterized-width flop with synchronous rst, clear and enable. It is instantiated once for the control bundle and once for the data/address bundle. The RdD==0 and ValidD gating stays in the parent.

Test Plan:
1. Reset then load: rst=1 for 2 cycles, release; drive RegWriteD=1, RdD=5, RD1D=32'h0000_00AA, ALUControlD=4'b0010. Next edge: RegWriteE=1, RdE=5, RD1E=32'h0000_00AA, ALUControlE=4'b0010. All E outputs are 0 during reset.
2. x0 write suppression: RegWriteD=1, RdD=0, ValidD=1. Next edge: RegWriteE=0, RdE=0.
3. Stall hold: load PCD=32'h0000_0100, then StallE=1 for 3 cycles with PCD=32'h0000_0200. PCE stays 32'h0000_0100 for all 3 cycles and becomes 32'h0000_0200 on the edge after StallE drops.
4. Flush vs stall: with MemWriteE=1 loaded, assert FlushE=1 and StallE=1 together. Next edge: MemWriteE=0, ValidE=0, RdE=0. With ID_EX_PERF_CNT_EN defined, BubbleCountE increments by exactly 1.
5. Invalid slot: ValidD=0, MemWriteD=1, BranchD=1, RdD=7. Next edge: MemWriteE=0, BranchE=0, RdE=7.
6. Counter saturation (ID_EX_PERF_CNT_EN defined): force counter to 32'hFFFF_FFFE, then StallE=1 for 3 cycles. BubbleCountE reads 32'hFFFF_FFFF and holds. Then rst=1 clears it to 0. With the macro undefined, BubbleCountE stays 0 throughout.
